// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the cache-to-main-memory controller.
// Provides block address/data types, the request type, the controller state
// encoding, the per-slot request payload and the port indices.
package mem_ctrl_pkg;

   localparam int unsigned N_PORTS      = 2;
   localparam int unsigned IC_PORT      = 0;
   localparam int unsigned DC_PORT      = 1;
   localparam int unsigned ADDR_W       = 29;
   localparam int unsigned DATA_W       = 64;
   localparam int unsigned RESP_TIMEOUT = 255;
   localparam int unsigned TO_CNT_W     = 8;

   typedef logic [ADDR_W-1:0] main_mem_block_addr_t;
   typedef logic [DATA_W-1:0] block_data_t;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_type_t;

   // Controller states: IDLE, ISSUE, WAIT_RESP, RESPOND
   typedef logic [1:0] mem_ctrl_state_t;
   localparam mem_ctrl_state_t ST_IDLE      = 2'd0;
   localparam mem_ctrl_state_t ST_ISSUE     = 2'd1;
   localparam mem_ctrl_state_t ST_WAIT_RESP = 2'd2;
   localparam mem_ctrl_state_t ST_RESPOND   = 2'd3;

   // One buffered block request
   typedef struct packed {
      req_type_t            req_type;
      main_mem_block_addr_t addr;
      block_data_t          data;
   } slot_req_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the icache, dcache and main-memory handshake signals.
// slave  : the controller side (mem_ctrl).
// master : the environment side (caches + main memory).
interface mem_ctrl_if;
   import mem_ctrl_pkg::*;

   logic                 ic_req_valid;
   main_mem_block_addr_t ic_req_block_addr;
   logic                 ic_req_ready;
   logic                 ic_resp_valid;
   block_data_t          ic_resp_block_data;

   logic                 dc_req_valid;
   req_type_t            dc_req_type;
   main_mem_block_addr_t dc_req_block_addr;
   block_data_t          dc_req_block_data;
   logic                 dc_req_ready;
   logic                 dc_resp_valid;
   block_data_t          dc_resp_block_data;

   logic                 mm_req_valid;
   req_type_t            mm_req_type;
   main_mem_block_addr_t mm_req_block_addr;
   block_data_t          mm_req_block_data;
   logic                 mm_req_ready;
   logic                 mm_resp_valid;
   block_data_t          mm_resp_block_data;

   modport slave (
      input  ic_req_valid, ic_req_block_addr,
      output ic_req_ready, ic_resp_valid, ic_resp_block_data,
      input  dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
      output dc_req_ready, dc_resp_valid, dc_resp_block_data,
      output mm_req_valid, mm_req_type, mm_req_block_addr, mm_req_block_data,
      input  mm_req_ready, mm_resp_valid, mm_resp_block_data
   );

   modport master (
      output ic_req_valid, ic_req_block_addr,
      input  ic_req_ready, ic_resp_valid, ic_resp_block_data,
      output dc_req_valid, dc_req_type, dc_req_block_addr, dc_req_block_data,
      input  dc_req_ready, dc_resp_valid, dc_resp_block_data,
      input  mm_req_valid, mm_req_type, mm_req_block_addr, mm_req_block_data,
      output mm_req_ready, mm_resp_valid, mm_resp_block_data
   );

endinterface

// File: rtl/mem_ctrl_slot.sv
// One-entry request holding register for a single cache port.
// Ports: clk, init (async active-high reset), set_i (load req_i),
//        clr_i (release entry), req_i (incoming request),
//        valid_o (entry occupied), req_o (held request).
module mem_ctrl_slot
   import mem_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      init,
   input  logic      set_i,
   input  logic      clr_i,
   input  slot_req_t req_i,
   output logic      valid_o,
   output slot_req_t req_o
);

   logic      valid_q;
   slot_req_t req_q;

   // set only happens on an empty slot and clr only on a full one
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else if (set_i) begin
         valid_q <= 1'b1;
         req_q   <= req_i;
      end else if (clr_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign req_o   = req_q;

endmodule

// File: rtl/mem_ctrl.sv
// Cache-to-main-memory controller: buffers one request per cache, grants
// icache first, runs one main-memory transaction at a time and returns the
// block to the requester as a single-cycle pulse.
// Ports: clk, init (async active-high reset), bus (mem_ctrl_if.slave:
//        icache/dcache request+response, main-memory request+response),
//        err_timeout (one-cycle pulse when a response is overdue).
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      init,
   mem_ctrl_if.slave bus,
   output logic      err_timeout
);

   localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(RESP_TIMEOUT);
   localparam logic [TO_CNT_W-1:0] TO_MAX   = '1;

   logic      ic_set, dc_set, ic_clr, dc_clr, ic_valid, dc_valid;
   slot_req_t ic_new, dc_new, ic_slot, dc_slot;
   logic      ic_pend, dc_pend;
   slot_req_t ic_cur, dc_cur;

   mem_ctrl_state_t         state_q, state_d;
   logic                    grant_q, grant_d;      // 1 = dcache holds the grant
   slot_req_t               req_q, req_d;          // request presented to memory
   block_data_t             resp_buf_q, resp_buf_d;
   logic [TO_CNT_W-1:0]     cnt_q, cnt_d;
   logic                    err_q, err_d;
   logic                    mm_valid_q, mm_valid_d;
   logic                    ic_resp_q, ic_resp_d;
   logic                    dc_resp_q, dc_resp_d;
   logic                    mm_seen_q, mm_seen_d;  // memory addressed since reset

   // Incoming request payloads; icache only ever reads
   always_comb begin
      ic_new          = '0;
      ic_new.req_type = REQ_READ;
      ic_new.addr     = bus.ic_req_block_addr;
      dc_new.req_type = bus.dc_req_type;
      dc_new.addr     = bus.dc_req_block_addr;
      dc_new.data     = bus.dc_req_block_data;
   end

   assign ic_set = bus.ic_req_valid & ~ic_valid;
   assign dc_set = bus.dc_req_valid & ~dc_valid;

   mem_ctrl_slot u_ic_slot (
      .clk(clk), .init(init), .set_i(ic_set), .clr_i(ic_clr),
      .req_i(ic_new), .valid_o(ic_valid), .req_o(ic_slot)
   );

   mem_ctrl_slot u_dc_slot (
      .clk(clk), .init(init), .set_i(dc_set), .clr_i(dc_clr),
      .req_i(dc_new), .valid_o(dc_valid), .req_o(dc_slot)
   );

   // IDLE looks through the slot at a request arriving this cycle so the
   // memory request can go out on the very next cycle
   assign ic_pend = ic_valid | ic_set;
   assign dc_pend = dc_valid | dc_set;
   assign ic_cur  = ic_valid ? ic_slot : ic_new;
   assign dc_cur  = dc_valid ? dc_slot : dc_new;

   // Next state, grant, response buffer and timeout counter
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      req_d      = req_q;
      resp_buf_d = resp_buf_q;
      cnt_d      = '0;
      mm_seen_d  = mm_seen_q;
      ic_clr     = 1'b0;
      dc_clr     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ic_pend) begin
               state_d = ST_ISSUE;
               grant_d = 1'b0;
               req_d   = ic_cur;
            end else if (dc_pend) begin
               state_d = ST_ISSUE;
               grant_d = 1'b1;
               req_d   = dc_cur;
            end
         end
         ST_ISSUE: begin
            if (bus.mm_req_ready) begin
               state_d   = ST_WAIT_RESP;
               mm_seen_d = 1'b1;
            end
         end
         ST_WAIT_RESP: begin
            if (bus.mm_resp_valid) begin
               state_d    = ST_RESPOND;
               resp_buf_d = (req_q.req_type == REQ_WRITE) ? req_q.data
                                                          : bus.mm_resp_block_data;
            end else begin
               cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + TO_CNT_W'(1);
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
            ic_clr  = ~grant_q;
            dc_clr  = grant_q;
         end
         default: state_d = ST_IDLE;
      endcase

      mm_valid_d = (state_d == ST_ISSUE);
      ic_resp_d  = (state_d == ST_RESPOND) & ~grant_d;
      dc_resp_d  = (state_d == ST_RESPOND) & grant_d;
      // fires only on the cycle the counter first reaches the limit
      err_d      = (state_q == ST_WAIT_RESP) && (state_d == ST_WAIT_RESP) &&
                   (cnt_d == TO_LIMIT) && (cnt_q != TO_LIMIT);
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state_q    <= ST_IDLE;
         grant_q    <= 1'b0;
         req_q      <= '0;
         resp_buf_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         mm_valid_q <= 1'b0;
         ic_resp_q  <= 1'b0;
         dc_resp_q  <= 1'b0;
         mm_seen_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         req_q      <= req_d;
         resp_buf_q <= resp_buf_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         mm_valid_q <= mm_valid_d;
         ic_resp_q  <= ic_resp_d;
         dc_resp_q  <= dc_resp_d;
         mm_seen_q  <= mm_seen_d;
      end
   end

   assign bus.ic_req_ready       = ~ic_valid;
   assign bus.dc_req_ready       = ~dc_valid;
   assign bus.ic_resp_valid      = ic_resp_q;
   assign bus.dc_resp_valid      = dc_resp_q;
   assign bus.ic_resp_block_data = resp_buf_q;
   assign bus.dc_resp_block_data = resp_buf_q;
   assign bus.mm_req_valid       = mm_valid_q;
   assign bus.mm_req_type        = req_q.req_type;
   assign bus.mm_req_block_addr  = req_q.addr;
   assign bus.mm_req_block_data  = req_q.data;
   assign err_timeout            = err_q;

   // An icache request into a full slot would be lost
   assert property (@(posedge clk) disable iff (init)
      bus.ic_req_valid |-> !ic_valid)
      else $error("icache request dropped: slot occupied");

   // Stray memory response; leftovers from before a reset are tolerated
   assert property (@(posedge clk) disable iff (init)
      (bus.mm_resp_valid && mm_seen_q) |-> (state_q == ST_WAIT_RESP))
      else $error("main-memory response outside WAIT_RESP ignored");

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk = 1'b0;
   logic init;
   logic err_timeout;

   mem_ctrl_if bus();

   mem_ctrl dut (
      .clk(clk),
      .init(init),
      .bus(bus),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Pending requests per port, the transaction in flight (port, accepted by
   // memory, cycles spent waiting) and the response pulse due this cycle.
   logic        m_v[2];
   req_type_t   m_t[2];
   logic [28:0] m_a[2];
   logic [63:0] m_d[2];
   int          m_cur;
   logic        m_sent;
   int          m_wait;
   int          m_pulse;
   logic [63:0] m_pdata;

   always @(negedge clk) begin
      if (init) begin
         chk("rst_ic_ready", 64'(bus.ic_req_ready), 64'(1));
         chk("rst_dc_ready", 64'(bus.dc_req_ready), 64'(1));
         chk("rst_mm_valid", 64'(bus.mm_req_valid), 64'(0));
         chk("rst_mm_addr", 64'(bus.mm_req_block_addr), 64'(0));
         chk("rst_ic_resp", 64'(bus.ic_resp_valid), 64'(0));
         chk("rst_dc_resp", 64'(bus.dc_resp_valid), 64'(0));
         chk("rst_err", 64'(err_timeout), 64'(0));
         for (int p = 0; p < 2; p++) begin
            m_v[p] = 1'b0; m_t[p] = REQ_READ; m_a[p] = '0; m_d[p] = '0;
         end
         m_cur = -1; m_sent = 1'b0; m_wait = 0; m_pulse = -1; m_pdata = '0;
      end else begin
         logic acc_ic, acc_dc;
         // compare this cycle's outputs
         chk("ic_req_ready", 64'(bus.ic_req_ready), 64'(!m_v[0]));
         chk("dc_req_ready", 64'(bus.dc_req_ready), 64'(!m_v[1]));
         chk("mm_req_valid", 64'(bus.mm_req_valid), 64'(m_cur >= 0 && !m_sent));
         if (m_cur >= 0 && !m_sent) begin
            chk("mm_req_type", 64'(bus.mm_req_type), 64'(m_t[m_cur]));
            chk("mm_req_addr", 64'(bus.mm_req_block_addr), 64'(m_a[m_cur]));
            if (m_t[m_cur] == REQ_WRITE)
               chk("mm_req_data", bus.mm_req_block_data, m_d[m_cur]);
         end
         chk("ic_resp_valid", 64'(bus.ic_resp_valid), 64'(m_pulse == 0));
         chk("dc_resp_valid", 64'(bus.dc_resp_valid), 64'(m_pulse == 1));
         if (m_pulse == 0) chk("ic_resp_data", bus.ic_resp_block_data, m_pdata);
         if (m_pulse == 1) chk("dc_resp_data", bus.dc_resp_block_data, m_pdata);
         chk("err_timeout", 64'(err_timeout),
             64'(m_cur >= 0 && m_sent && m_wait == int'(RESP_TIMEOUT)));

         // advance the model by one cycle
         acc_ic = bus.ic_req_valid && !m_v[0];
         acc_dc = bus.dc_req_valid && !m_v[1];
         if (m_pulse >= 0) m_v[m_pulse] = 1'b0;
         if (acc_ic) begin
            m_v[0] = 1'b1; m_t[0] = REQ_READ; m_a[0] = bus.ic_req_block_addr; m_d[0] = '0;
         end
         if (acc_dc) begin
            m_v[1] = 1'b1; m_t[1] = bus.dc_req_type; m_a[1] = bus.dc_req_block_addr;
            m_d[1] = bus.dc_req_block_data;
         end
         if (m_pulse >= 0) begin
            m_pulse = -1;                       // the cycle after a response is a bubble
         end else if (m_cur < 0) begin
            if (m_v[0]) m_cur = 0;
            else if (m_v[1]) m_cur = 1;
            m_sent = 1'b0;
         end else if (!m_sent) begin
            if (bus.mm_req_ready) begin m_sent = 1'b1; m_wait = 0; end
         end else if (bus.mm_resp_valid) begin
            m_pulse = m_cur;
            m_pdata = (m_t[m_cur] == REQ_WRITE) ? m_d[m_cur] : bus.mm_resp_block_data;
            m_cur   = -1;
         end else begin
            m_wait++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int errs;
   int err_at;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      init                   = 1'b1;
      bus.ic_req_valid       = 1'b0;
      bus.ic_req_block_addr  = '0;
      bus.dc_req_valid       = 1'b0;
      bus.dc_req_type        = REQ_READ;
      bus.dc_req_block_addr  = '0;
      bus.dc_req_block_data  = '0;
      bus.mm_req_ready       = 1'b1;
      bus.mm_resp_valid      = 1'b0;
      bus.mm_resp_block_data = '0;
      repeat (3) tick();
      init = 1'b0;
      tick();

      // T1: icache read, response three cycles after the memory request
      bus.ic_req_valid = 1'b1; bus.ic_req_block_addr = 29'h40;
      tick();
      bus.ic_req_valid = 1'b0;
      chk("t1_mm_valid", 64'(bus.mm_req_valid), 64'(1));
      chk("t1_mm_addr", 64'(bus.mm_req_block_addr), 64'h40);
      repeat (3) tick();
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'hDEADBEEF_CAFEF00D;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t1_ic_resp", 64'(bus.ic_resp_valid), 64'(1));
      chk("t1_ic_data", bus.ic_resp_block_data, 64'hDEADBEEF_CAFEF00D);
      chk("t1_dc_resp", 64'(bus.dc_resp_valid), 64'(0));
      tick();
      chk("t1_ic_pulse_end", 64'(bus.ic_resp_valid), 64'(0));
      tick();

      // T2: simultaneous icache and dcache reads; icache goes first
      bus.ic_req_valid = 1'b1; bus.ic_req_block_addr = 29'h10;
      bus.dc_req_valid = 1'b1; bus.dc_req_type = REQ_READ; bus.dc_req_block_addr = 29'h20;
      tick();
      bus.ic_req_valid = 1'b0; bus.dc_req_valid = 1'b0;
      chk("t2_first_addr", 64'(bus.mm_req_block_addr), 64'h10);
      chk("t2_dc_ready_lo", 64'(bus.dc_req_ready), 64'(0));
      tick();
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'h0101_0202_0303_0404;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t2_ic_resp", 64'(bus.ic_resp_valid), 64'(1));
      chk("t2_dc_ready_hold", 64'(bus.dc_req_ready), 64'(0));
      tick();
      chk("t2_bubble", 64'(bus.mm_req_valid), 64'(0));
      tick();
      chk("t2_second_valid", 64'(bus.mm_req_valid), 64'(1));
      chk("t2_second_addr", 64'(bus.mm_req_block_addr), 64'h20);
      tick();
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'hA5A5_5A5A_0F0F_F0F0;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t2_dc_resp", 64'(bus.dc_resp_valid), 64'(1));
      chk("t2_dc_data", bus.dc_resp_block_data, 64'hA5A5_5A5A_0F0F_F0F0);
      tick();
      chk("t2_dc_ready_back", 64'(bus.dc_req_ready), 64'(1));
      tick();

      // T3: dcache write with memory back-pressure for four cycles
      bus.mm_req_ready = 1'b0;
      bus.dc_req_valid = 1'b1; bus.dc_req_type = REQ_WRITE;
      bus.dc_req_block_addr = 29'h30; bus.dc_req_block_data = 64'h1122334455667788;
      tick();
      bus.dc_req_valid = 1'b0; bus.dc_req_type = REQ_READ;
      bus.dc_req_block_addr = 29'h1FFF_FFFF; bus.dc_req_block_data = '1;
      for (int i = 0; i < 4; i++) begin
         chk("t3_stall_valid", 64'(bus.mm_req_valid), 64'(1));
         chk("t3_stall_type", 64'(bus.mm_req_type), 64'(REQ_WRITE));
         chk("t3_stall_addr", 64'(bus.mm_req_block_addr), 64'h30);
         chk("t3_stall_data", bus.mm_req_block_data, 64'h1122334455667788);
         tick();
      end
      bus.mm_req_ready = 1'b1;
      tick();
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'hFFFF_0000_FFFF_0000;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t3_dc_resp", 64'(bus.dc_resp_valid), 64'(1));
      chk("t3_write_echo", bus.dc_resp_block_data, 64'h1122334455667788);
      repeat (2) tick();

      // T4: reset while waiting for memory, then a stale response
      bus.dc_req_valid = 1'b1; bus.dc_req_type = REQ_READ; bus.dc_req_block_addr = 29'h50;
      tick();
      bus.dc_req_valid = 1'b0;
      tick();
      init = 1'b1;
      tick();
      init = 1'b0;
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'h5555_6666_7777_8888;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t4_no_dc_resp", 64'(bus.dc_resp_valid), 64'(0));
      chk("t4_no_ic_resp", 64'(bus.ic_resp_valid), 64'(0));
      chk("t4_ic_ready", 64'(bus.ic_req_ready), 64'(1));
      chk("t4_dc_ready", 64'(bus.dc_req_ready), 64'(1));
      chk("t4_mm_idle", 64'(bus.mm_req_valid), 64'(0));
      tick();
      chk("t4_still_quiet", 64'(bus.dc_resp_valid), 64'(0));
      tick();

      // T5: memory never answers; one timeout pulse, late answer still delivered
      bus.dc_req_valid = 1'b1; bus.dc_req_type = REQ_READ; bus.dc_req_block_addr = 29'h60;
      tick();
      bus.dc_req_valid = 1'b0;
      tick();
      errs = 0; err_at = -1;
      for (int i = 0; i < 300; i++) begin
         if (err_timeout) begin
            errs++;
            if (err_at < 0) err_at = i;
         end
         tick();
      end
      chk("t5_err_count", 64'(errs), 64'(1));
      chk("t5_err_cycle", 64'(err_at), 64'(255));
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'h0BAD_F00D_1234_5678;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t5_late_resp", 64'(bus.dc_resp_valid), 64'(1));
      chk("t5_late_data", bus.dc_resp_block_data, 64'h0BAD_F00D_1234_5678);
      repeat (2) tick();

      // T6: icache request lands in the dcache RESPOND cycle
      bus.dc_req_valid = 1'b1; bus.dc_req_type = REQ_READ; bus.dc_req_block_addr = 29'h70;
      tick();
      bus.dc_req_valid = 1'b0;
      tick();
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'h7070_7070_7070_7070;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t6_dc_resp", 64'(bus.dc_resp_valid), 64'(1));
      chk("t6_ic_ready", 64'(bus.ic_req_ready), 64'(1));
      bus.ic_req_valid = 1'b1; bus.ic_req_block_addr = 29'h80;
      tick();
      bus.ic_req_valid = 1'b0;
      chk("t6_idle_gap", 64'(bus.mm_req_valid), 64'(0));
      chk("t6_ic_held", 64'(bus.ic_req_ready), 64'(0));
      tick();
      chk("t6_ic_issue", 64'(bus.mm_req_valid), 64'(1));
      chk("t6_ic_addr", 64'(bus.mm_req_block_addr), 64'h80);
      tick();
      bus.mm_resp_valid = 1'b1; bus.mm_resp_block_data = 64'h8080_8080_0000_1111;
      tick();
      bus.mm_resp_valid = 1'b0;
      chk("t6_ic_resp", 64'(bus.ic_resp_valid), 64'(1));
      chk("t6_ic_data", bus.ic_resp_block_data, 64'h8080_8080_0000_1111);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
